// File: rtl/cipher_pkg.sv
// Shared definitions for the double-buffered XOR-cipher key assembler:
// controller state encoding, word-order encoding and word-slice placement.
package cipher_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    localparam int unsigned ORDER_LSB_FIRST = 0;
    localparam int unsigned ORDER_MSB_FIRST = 1;

    // Lowest bit index of key word idx inside the assembled key.
    function automatic int unsigned word_base(
        input int unsigned idx,
        input int unsigned word_w,
        input int unsigned key_w,
        input int unsigned msb_first
    );
        if (msb_first == ORDER_MSB_FIRST) begin
            return key_w - (idx + 1) * word_w;
        end
        return idx * word_w;
    endfunction

endpackage

// File: rtl/key_shadow_reg.sv
// Shadow key register: word-indexed write port plus a synchronous clear.
// The clear wins over a write issued in the same cycle.
module key_shadow_reg
    import cipher_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned KEY_W     = 512,
    parameter int unsigned MSB_FIRST = 0,
    localparam int unsigned NWORDS   = KEY_W / WORD_W,
    localparam int unsigned CW       = $clog2(NWORDS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [CW-1:0]     idx_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [KEY_W-1:0]  shadow_o
);

    logic [KEY_W-1:0] shadow_q;
    logic [KEY_W-1:0] shadow_d;

    // Next shadow value: clear, or drop the incoming word into its slice.
    always_comb begin
        shadow_d = shadow_q;
        if (clr_i) begin
            shadow_d = '0;
        end else if (we_i) begin
            for (int unsigned k = 0; k < NWORDS; k++) begin
                if (idx_i == CW'(k)) begin
                    shadow_d[word_base(k, WORD_W, KEY_W, MSB_FIRST) +: WORD_W] = word_i;
                end
            end
        end
    end

    // Shadow storage, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/key_assembler_dbuf.sv
// Double-buffered key assembler: fills a shadow register word by word and
// commits a complete key atomically to the active key, held off by iHold.
//
//   state    | meaning
//   S_IDLE   | first cycle after reset release, no words accepted
//   S_FILL   | accepting key words into the shadow register
//   S_COMMIT | shadow full, waiting for iHold low to publish the key
module key_assembler_dbuf
    import cipher_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned KEY_W     = 512,
    parameter int unsigned MSB_FIRST = 0,
    localparam int unsigned NWORDS   = KEY_W / WORD_W,
    localparam int unsigned CW       = $clog2(NWORDS + 1)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClear,
    input  logic              iWord_valid,
    input  logic [WORD_W-1:0] iWord,
    output logic              oWord_ready,
    input  logic              iHold,
    output logic [KEY_W-1:0]  oKey,
    output logic              oKey_valid,
    output logic              oKey_update,
    output logic [CW-1:0]     oWords_loaded
);

    if ((KEY_W % WORD_W) != 0 || (KEY_W / WORD_W) < 2) begin : g_bad_params
        $error("key_assembler_dbuf: KEY_W must be a multiple of WORD_W holding at least two words");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             update_q, update_d;
    logic             shadow_we;
    logic             shadow_clr;
    logic [KEY_W-1:0] shadow;
    logic             word_ready;
    logic             accept;

    assign word_ready = (state_q == S_FILL) && !iClear;
    assign accept     = iWord_valid && word_ready;

    key_shadow_reg #(
        .WORD_W    (WORD_W),
        .KEY_W     (KEY_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shadow (
        .clk_i    (iClk),
        .rst_ni   (iRst),
        .clr_i    (shadow_clr),
        .we_i     (shadow_we),
        .idx_i    (count_q),
        .word_i   (iWord),
        .shadow_o (shadow)
    );

    // Next state, word count and commit of the shadow into the active key.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        update_d    = 1'b0;
        shadow_we   = 1'b0;
        shadow_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FILL;
            end
            S_FILL: begin
                if (iClear) begin
                    shadow_clr = 1'b1;
                    count_d    = '0;
                end else if (accept) begin
                    shadow_we = 1'b1;
                    count_d   = count_q + CW'(1);
                    if (count_q == CW'(NWORDS - 1)) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                if (iClear) begin
                    shadow_clr = 1'b1;
                    count_d    = '0;
                    state_d    = S_FILL;
                end else if (!iHold) begin
                    key_d       = shadow;
                    key_valid_d = 1'b1;
                    update_d    = 1'b1;
                    shadow_clr  = 1'b1;
                    count_d     = '0;
                    state_d     = S_FILL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller and active-key registers; reset discards everything.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            update_q    <= update_d;
        end
    end

    assign oWord_ready   = word_ready;
    assign oKey          = key_q;
    assign oKey_valid    = key_valid_q;
    assign oKey_update   = update_q;
    assign oWords_loaded = count_q;

endmodule

// File: tb/tb_key_assembler_dbuf.sv
// Bench for key_assembler_dbuf: a default 32/512 LSB-first instance checked
// against a queue-based key model, plus an 8/32 MSB-first instance.
module tb_key_assembler_dbuf;

    logic iClk = 1'b0;
    logic iRst;
    always #5 iClk = ~iClk;

    logic         c0, v0, h0;
    logic [31:0]  w0;
    logic         rdy0, kv0, ku0;
    logic [511:0] key0;
    logic [4:0]   wl0;

    logic         c1, v1, h1;
    logic [7:0]   w1;
    logic         rdy1, kv1, ku1;
    logic [31:0]  key1;
    logic [2:0]   wl1;

    key_assembler_dbuf dut0 (
        .iClk(iClk), .iRst(iRst), .iClear(c0), .iWord_valid(v0), .iWord(w0),
        .oWord_ready(rdy0), .iHold(h0), .oKey(key0), .oKey_valid(kv0),
        .oKey_update(ku0), .oWords_loaded(wl0)
    );

    key_assembler_dbuf #(.WORD_W(8), .KEY_W(32), .MSB_FIRST(1)) dut1 (
        .iClk(iClk), .iRst(iRst), .iClear(c1), .iWord_valid(v1), .iWord(w1),
        .oWord_ready(rdy1), .iHold(h1), .oKey(key1), .oKey_valid(kv1),
        .oKey_update(ku1), .oWords_loaded(wl1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: accepted words in order, published key and flags.
    logic [31:0]  mq[$];
    logic [511:0] m_key;
    logic         m_valid, m_upd, m_active, m_pending;
    logic         acc;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] build_key();
        logic [511:0] k = '0;
        foreach (mq[i]) k[i*32 +: 32] = mq[i];
        return k;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_key = '0; m_valid = 0; m_upd = 0; m_active = 0; m_pending = 0;
    endtask

    // One clock of dut0: drive, check ready, clock, update model, check outputs.
    task automatic step0(input logic v, input logic [31:0] w, input logic h,
                         input logic c, output logic accepted);
        logic exp_rdy;
        v0 = v; w0 = w; h0 = h; c0 = c;
        #1;
        exp_rdy = m_active && !m_pending && !c;
        chk("ready0", {511'd0, rdy0}, {511'd0, exp_rdy});
        accepted = exp_rdy && v;
        @(posedge iClk); #1;
        m_upd = 0;
        if (!m_active) begin
            m_active = 1;
        end else if (c) begin
            mq.delete();
            m_pending = 0;
        end else if (m_pending) begin
            if (!h) begin
                m_key = build_key(); m_valid = 1; m_upd = 1;
                mq.delete(); m_pending = 0;
            end
        end else if (accepted) begin
            mq.push_back(w);
            if (mq.size() == 16) m_pending = 1;
        end
        chk("key0",    key0, m_key);
        chk("valid0",  {511'd0, kv0}, {511'd0, m_valid});
        chk("update0", {511'd0, ku0}, {511'd0, m_upd});
        chk("loaded0", {507'd0, wl0}, 512'(mq.size()));
    endtask

    initial begin
        logic [7:0] b1 [4];
        logic [31:0] word;
        int idx, cyc;
        b1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        iRst = 0;
        c0 = 0; v0 = 0; h0 = 0; w0 = '0;
        c1 = 0; v1 = 0; h1 = 0; w1 = '0;
        model_reset();
        @(posedge iClk); @(posedge iClk); #1;
        chk("rst_key0",   key0, '0);
        chk("rst_ready0", {511'd0, rdy0}, '0);
        chk("rst_loaded0", {507'd0, wl0}, '0);
        chk("rst_key1",   {480'd0, key1}, '0);
        #3 iRst = 1;

        // Basic fill: words 0..15, commit one cycle after the 16th accept.
        step0(0, 32'h0, 0, 1, acc);
        for (int i = 0; i < 16; i++) step0(1, 32'(i), 0, 0, acc);
        step0(0, 32'h0, 0, 0, acc);
        chk("basic_lo",  {480'd0, key0[31:0]},    512'h0);
        chk("basic_hi",  {480'd0, key0[511:480]}, 512'hF);
        chk("basic_upd", {511'd0, ku0}, 512'd1);
        step0(0, 32'h0, 0, 0, acc);

        // MSB-first 8/32 instance.
        for (int i = 0; i < 4; i++) begin
            v1 = 1; w1 = b1[i];
            #1 chk("ready1", {511'd0, rdy1}, 512'd1);
            @(posedge iClk); #1;
            chk("loaded1", {509'd0, wl1}, 512'(i + 1));
        end
        v1 = 0;
        #1 chk("ready1_commit", {511'd0, rdy1}, 512'd0);
        @(posedge iClk); #1;
        chk("key1",     {480'd0, key1}, {480'd0, 32'hA1B2C3D4});
        chk("update1",  {511'd0, ku1}, 512'd1);
        chk("valid1",   {511'd0, kv1}, 512'd1);
        chk("loaded1_0", {509'd0, wl1}, 512'd0);
        #1 chk("ready1_after", {511'd0, rdy1}, 512'd1);
        @(posedge iClk); #1;
        chk("update1_off", {511'd0, ku1}, 512'd0);

        // Hold: iHold high from the last word for 5 cycles; offered words ignored.
        for (int i = 0; i < 15; i++) step0(1, $urandom, 0, 0, acc);
        step0(1, $urandom, 1, 0, acc);
        for (int i = 0; i < 4; i++) step0(1, $urandom, 1, 0, acc);
        step0(0, 32'h0, 0, 0, acc);
        step0(0, 32'h0, 0, 0, acc);

        // Abort a partial load, then load a fresh key.
        for (int i = 0; i < 7; i++) step0(1, $urandom, 0, 0, acc);
        step0(1, 32'hDEADBEEF, 0, 1, acc);
        for (int i = 0; i < 16; i++) step0(1, $urandom, 0, 0, acc);
        step0(0, 32'h0, 0, 0, acc);

        // Clear while a commit is pending suppresses it.
        for (int i = 0; i < 15; i++) step0(1, $urandom, 0, 0, acc);
        step0(1, $urandom, 1, 0, acc);
        step0(0, 32'h0, 0, 1, acc);
        step0(0, 32'h0, 0, 0, acc);

        // Back-pressure: random valid with about 30% idle, three keys.
        for (int k = 0; k < 3; k++) begin
            idx = 0; cyc = 0; word = $urandom;
            while (idx < 16 && cyc < 200) begin
                step0(($urandom_range(0, 9) >= 3), word, 0, 0, acc);
                if (acc) begin
                    idx++;
                    word = $urandom;
                end
                cyc++;
            end
            if (idx < 16) chk("bp_timeout", 512'(idx), 512'd16);
            step0(1, word, 0, 0, acc);
        end
        step0(0, 32'h0, 0, 0, acc);

        // Asynchronous reset after 10 words.
        for (int i = 0; i < 10; i++) step0(1, $urandom, 0, 0, acc);
        #2 iRst = 0;
        #1;
        chk("mrst_key0",   key0, '0);
        chk("mrst_valid0", {511'd0, kv0}, '0);
        chk("mrst_upd0",   {511'd0, ku0}, '0);
        chk("mrst_loaded0", {507'd0, wl0}, '0);
        chk("mrst_ready0", {511'd0, rdy0}, '0);
        model_reset();
        #2 iRst = 1;
        step0(1, 32'h1234, 0, 0, acc);
        for (int i = 0; i < 16; i++) step0(1, $urandom, 0, 0, acc);
        step0(0, 32'h0, 0, 0, acc);
        step0(0, 32'h0, 0, 0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
